// File: rtl/sprite_hit_scheduler_pkg.sv
// Shared constants and types for the sprite hit scheduler slice.
// Sprite entries are packed {blX, blY, width, height}, 16 bits each.
package sprite_hit_scheduler_pkg;

    localparam int unsigned SPRITE_W          = 64;
    localparam int unsigned BLX_HI            = 63;
    localparam int unsigned BLX_LO            = 48;
    localparam int unsigned BLY_HI            = 47;
    localparam int unsigned BLY_LO            = 32;
    localparam int unsigned W_HI              = 31;
    localparam int unsigned W_LO              = 16;
    localparam int unsigned H_HI              = 15;
    localparam int unsigned H_LO              = 0;
    localparam int unsigned SCREEN_H_DEFAULT  = 480;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } scanState_t;

endpackage

// File: rtl/sprite_hit_scheduler_point_test.sv
// Combinational point-in-box test for one sprite entry.
// Converts the y-down pixel to y-up space and applies strict bounds on both axes.
module sprite_point_test
    import sprite_hit_scheduler_pkg::*;
#(
    parameter int unsigned SCREEN_H = SCREEN_H_DEFAULT
) (
    input  logic [SPRITE_W-1:0] entry,
    input  logic [15:0]         pixX,
    input  logic [15:0]         pixY,
    input  logic                enable,
    output logic                hit
);

    localparam logic [15:0] FLIP_H = 16'(SCREEN_H);

    logic [15:0] blX, blY, boxW, boxH, transY;
    logic [16:0] rightX, topY;

    always_comb begin
        blX    = entry[BLX_HI:BLX_LO];
        blY    = entry[BLY_HI:BLY_LO];
        boxW   = entry[W_HI:W_LO];
        boxH   = entry[H_HI:H_LO];
        // Wraps for pixY > SCREEN_H, which lands far above any box
        transY = FLIP_H - pixY;
        rightX = {1'b0, blX} + {1'b0, boxW};
        topY   = {1'b0, blY} + {1'b0, boxH};
        hit    = enable
              && (pixX > blX) && ({1'b0, pixX} < rightX)
              && (transY > blY) && ({1'b0, transY} < topY);
    end

endmodule

// File: rtl/sprite_hit_scheduler.sv
// Scans the sprite table one entry per cycle through a single point tester,
// reporting the lowest-index enabled sprite that contains the requested pixel.
module sprite_hit_scheduler
    import sprite_hit_scheduler_pkg::*;
#(
    parameter int unsigned NUM_SPRITES = 4,
    parameter int unsigned IDX_W       = 2,
    parameter int unsigned SCREEN_H    = SCREEN_H_DEFAULT
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                wr_en,
    input  logic [IDX_W-1:0]    wr_idx,
    input  logic [SPRITE_W-1:0] wr_data,
    input  logic                wr_enable,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [15:0]         req_x,
    input  logic [15:0]         req_y,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic                rsp_hit,
    output logic [IDX_W-1:0]    rsp_idx
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SPRITES - 1);

    logic [SPRITE_W-1:0]    spriteTable [NUM_SPRITES];
    logic [NUM_SPRITES-1:0] spriteEn;
    scanState_t             state, stateNext;
    logic [15:0]            latchX, latchY;
    logic [IDX_W-1:0]       scanIdx;
    logic                   rspHitQ;
    logic [IDX_W-1:0]       rspIdxQ;
    logic [SPRITE_W-1:0]    curEntry;
    logic                   curEn;
    logic                   curHit;
    logic                   wrInRange;

    assign wrInRange = (32'(wr_idx) < NUM_SPRITES);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_SPRITES; i++) begin
                spriteTable[i] <= '0;
            end
            spriteEn <= '0;
        end else if (wr_en && wrInRange) begin
            spriteTable[wr_idx] <= wr_data;
            spriteEn[wr_idx]    <= wr_enable;
        end
    end

    assign curEntry = spriteTable[scanIdx];
    assign curEn    = spriteEn[scanIdx];

    sprite_point_test #(
        .SCREEN_H (SCREEN_H)
    ) u_pointTest (
        .entry  (curEntry),
        .pixX   (latchX),
        .pixY   (latchY),
        .enable (curEn),
        .hit    (curHit)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        unique case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) stateNext = SCAN;
            end
            SCAN: begin
                if (curHit || (scanIdx == LAST_IDX)) stateNext = DONE;
            end
            DONE: begin
                rsp_valid = 1'b1;
                if (rsp_ready) stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            latchX  <= '0;
            latchY  <= '0;
            scanIdx <= '0;
            rspHitQ <= 1'b0;
            rspIdxQ <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        latchX  <= req_x;
                        latchY  <= req_y;
                        scanIdx <= '0;
                    end
                end
                SCAN: begin
                    if (curHit) begin
                        rspHitQ <= 1'b1;
                        rspIdxQ <= scanIdx;
                    end else if (scanIdx == LAST_IDX) begin
                        rspHitQ <= 1'b0;
                        rspIdxQ <= '0;
                    end else begin
                        scanIdx <= scanIdx + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign rsp_hit = rspHitQ;
    assign rsp_idx = rspIdxQ;

endmodule

// File: doc/sprite_hit_scheduler.md
Name: sprite_hit_scheduler

Overview:
Time-multiplexes one combinational point-in-sprite test across a table of NUM_SPRITES sprite boxes. It accepts a screen pixel request and scans the sprites in index order, one per cycle. It returns the lowest-index enabled sprite containing the pixel, or a miss. It sits between the pixel/hitbox query logic and the sprite register table, replacing N parallel comparators with one.

Parameters:
NUM_SPRITES, 4, number of sprite table entries (2..16)
IDX_W, 2, width of sprite index; must equal clog2(NUM_SPRITES)
SCREEN_H, 480, screen height used for the y-axis flip

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
wr_en  in  1  sprite table write strobe
wr_idx  in  IDX_W  entry written
wr_data  in  64  {blX[63:48], blY[47:32], width[31:16], height[15:0]}, y-up coordinates
wr_enable  in  1  enable bit stored with the entry
req_valid  in  1  pixel query valid
req_ready  out  1  scheduler can accept a query
req_x  in  16  pixel x, screen coordinates
req_y  in  16  pixel y, screen coordinates, y pointing down
rsp_valid  out  1  result valid
rsp_ready  in  1  consumer accepts result
rsp_hit  out  1  1 = some enabled sprite contains the pixel
rsp_idx  out  IDX_W  lowest hitting index; 0 on miss

Behaviour:
- Reset (async, active-high): state IDLE; all table entries, enables, latched x/y, scan index, rsp_hit and rsp_idx go to 0; rsp_valid=0; req_ready=1 once the FSM is in IDLE.
- Table write: on a clock edge with wr_en, entry[wr_idx] <= wr_data and en[wr_idx] <= wr_enable. Allowed in any state. A scan cycle testing the same entry uses the pre-edge value.
- Point test (combinational):
  - transY = SCREEN_H - y, 16-bit two's-complement wrap.
  - top = bl + size, computed at 17 bits with no overflow.
  - Hit requires: enabled, and x > blX, x < blX+width, transY > blY, transY < blY+height. All compares are unsigned and strict, so edges count as misses.
- FSM states IDLE, SCAN, DONE:
  - IDLE: req_ready=1. When req_valid && req_ready at edge E0: latch req_x/req_y, index <= 0, go to SCAN.
  - SCAN: req_ready=0. Each cycle tests entry[index].
    - Hit: at the edge, rsp_hit <= 1, rsp_idx <= index, go to DONE.
    - Miss with index == NUM_SPRITES-1: rsp_hit <= 0, rsp_idx <= 0, go to DONE.
    - Otherwise index <= index+1.
  - DONE: rsp_valid=1; rsp_hit and rsp_idx hold stable. When rsp_ready is high at an edge, go to IDLE. req_ready returns to 1 in the following cycle; there is no back-to-back accept in the same cycle as the response handshake.
- Latency, counted in edges after E0 until rsp_valid is sampled high:
  - hit at index k: k+1
  - miss: NUM_SPRITES
  - throughput is at most one query per latency+2 cycles
- Priority: the lowest index wins, through early termination of the scan.
- req_x/req_y changes after acceptance have no effect on the query in flight.
- Reset mid-SCAN or mid-DONE aborts the query immediately. No response is produced, and the table is cleared.
- y wrap: req_y > SCREEN_H gives a large transY, normally a miss. No special casing.

Decomposition:
- Shared package contents:
  - SPRITE_W=64
  - field bit offsets BLX_HI/LO, BLY_HI/LO, W_HI/LO, H_HI/LO
  - SCREEN_H constant
  - state enum {IDLE, SCAN, DONE}
- One natural sub-module, sprite_point_test: the combinational flip and compare (64-bit entry, x, y, enable in; hit out), instantiated once and fed through a mux on the scan index.

Test Plan:
1. Write entry0=0x0064_00C8_0032_0028 (x100,y200,w50,h40), enabled; query (120,260), giving transY=220 -> rsp_hit=1, rsp_idx=0, rsp_valid 1 edge after accept.
2. Boundaries with the same entry: queries (100,260), (150,260), (120,280) and (120,240) -> all rsp_hit=0 after NUM_SPRITES=4 edges; query (101,279) -> hit idx0.
3. Priority: entry0 disabled; entries 1 and 2 both cover (120,260) -> rsp_idx=1, rsp_valid 2 edges after accept.
4. Backpressure: hold rsp_ready=0 for 5 cycles -> rsp_valid, rsp_hit and rsp_idx stable and req_ready=0; raise rsp_ready -> IDLE, req_ready=1 next cycle.
5. Write during scan: rewrite entry1 to miss in the cycle entry1 is tested -> that cycle still hits with the old value. A later query misses on idx1.
6. Assert reset during SCAN -> rsp_valid stays 0, req_ready=1 after release, all entries disabled (a query that hit before reset now misses).
